// File: rtl/nco_bank_if.sv
// ============================================================================
// nco_bank_if : run-control, configuration and address-output bundle for nco_bank
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface nco_bank_if #(
  parameter int NUM_CH    = 4,
  parameter int ADDR_BITS = 8,
  parameter int DIV_BITS  = 16,
  parameter int CH_BITS   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [NUM_CH-1:0]           ch_en;
  logic [NUM_CH-1:0]           sync;
  logic                        cfg_we;
  logic                        cfg_sel;
  logic [CH_BITS-1:0]          cfg_ch;
  logic [DIV_BITS-1:0]         cfg_data;
  logic [NUM_CH*ADDR_BITS-1:0] addr_out;
  logic [NUM_CH-1:0]           wrap_pulse;

  modport master (
    output ch_en, sync, cfg_we, cfg_sel, cfg_ch, cfg_data,
    input  addr_out, wrap_pulse
  );

  modport slave (
    input  ch_en, sync, cfg_we, cfg_sel, cfg_ch, cfg_data,
    output addr_out, wrap_pulse
  );
endinterface

`default_nettype wire

// File: rtl/nco_bank.sv
// ============================================================================
// nco_bank : bank of independent divider-paced phase counters with offset add
// Revision : 1.0
// ============================================================================
`default_nettype none

module nco_bank #(
  parameter int NUM_CH      = 4,
  parameter int ADDR_BITS   = 8,
  parameter int DIV_BITS    = 16,
  parameter int MIN_DIVIDER = 8
) (
  input  logic     sys_clk,
  input  logic     sys_rst_n,
  nco_bank_if.slave bus
);
  localparam int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [DIV_BITS-1:0] c_min_div = DIV_BITS'(MIN_DIVIDER);

  logic [NUM_CH*ADDR_BITS-1:0] addr_all;
  logic [NUM_CH-1:0]           wrap_all;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [DIV_BITS-1:0]  div_q, div_d, acc_q, acc_d, div_eff;
    logic [ADDR_BITS-1:0] off_q, off_d, phase_q, phase_d, addr_q, addr_d;
    logic                 wrap_q, wrap_d, wr_hit;

    // Out-of-range channel indices never match any gi, so such writes drop.
    always_comb begin
      div_eff = (div_q < c_min_div) ? c_min_div : div_q;
      wr_hit  = bus.cfg_we && (bus.cfg_ch == CH_BITS'(gi));
      div_d   = div_q;
      off_d   = off_q;
      acc_d   = '0;
      phase_d = phase_q;
      wrap_d  = 1'b0;
      if (wr_hit && !bus.cfg_sel) div_d = bus.cfg_data;
      if (wr_hit && bus.cfg_sel)  off_d = bus.cfg_data[ADDR_BITS-1:0];
      if (bus.sync[gi]) begin
        phase_d = '0;
      end else if (bus.ch_en[gi]) begin
        // >= rather than == so a divider rewritten below accum still steps.
        if (acc_q >= div_eff) begin
          phase_d = phase_q + 1'b1;
          wrap_d  = &phase_q;
        end else begin
          acc_d = acc_q + 1'b1;
        end
      end
      addr_d = phase_q + off_q;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        div_q   <= '0;
        off_q   <= '0;
        acc_q   <= '0;
        phase_q <= '0;
        addr_q  <= '0;
        wrap_q  <= 1'b0;
      end else begin
        div_q   <= div_d;
        off_q   <= off_d;
        acc_q   <= acc_d;
        phase_q <= phase_d;
        addr_q  <= addr_d;
        wrap_q  <= wrap_d;
      end
    end

    assign addr_all[gi*ADDR_BITS +: ADDR_BITS] = addr_q;
    assign wrap_all[gi]                        = wrap_q;
  end

  assign bus.addr_out   = addr_all;
  assign bus.wrap_pulse = wrap_all;
endmodule

`default_nettype wire

// File: tb/tb_nco_bank.sv
// ============================================================================
// tb_nco_bank : table-driven and scoreboarded checks of nco_bank
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_nco_bank;
  localparam int AB = 8;
  localparam int DB = 16;

  typedef struct {
    int ch;
    int dv;
    int off;
    int n;
    int first;
    int period;
  } vec_t;

  typedef struct {
    int cyc;
    int val;
  } exp_t;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  int   cyc       = 0;
  int   n_chk     = 0;
  int   n_pass    = 0;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  nco_bank_if #(.NUM_CH(4), .ADDR_BITS(AB), .DIV_BITS(DB)) bus ();
  nco_bank #(.NUM_CH(4), .ADDR_BITS(AB), .DIV_BITS(DB), .MIN_DIVIDER(8)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  nco_bank_if #(.NUM_CH(3), .ADDR_BITS(AB), .DIV_BITS(DB)) bus3 ();
  nco_bank #(.NUM_CH(3), .ADDR_BITS(AB), .DIV_BITS(DB), .MIN_DIVIDER(8)) dut3 (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus3)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int addr_of(input int ch);
    return int'(bus.addr_out[ch*AB +: AB]);
  endfunction

  task automatic clear_inputs();
    bus.ch_en    = '0;
    bus.sync     = '0;
    bus.cfg_we   = 1'b0;
    bus.cfg_sel  = 1'b0;
    bus.cfg_ch   = '0;
    bus.cfg_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    sys_rst_n = 1'b0;
    tick();
    tick();
    sys_rst_n = 1'b1;
  endtask

  task automatic wr(input logic sel, input int ch, input int data);
    bus.cfg_we   = 1'b1;
    bus.cfg_sel  = sel;
    bus.cfg_ch   = 2'(ch);
    bus.cfg_data = 16'(data);
    tick();
    bus.cfg_we   = 1'b0;
  endtask

  task automatic wait_change(input int ch, input int bound, output bit ok);
    int prev;
    prev = addr_of(ch);
    ok   = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (addr_of(ch) != prev) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_value(input int ch, input int val, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (addr_of(ch) == val) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t tbl[7];
    exp_t sb[$];
    exp_t e;
    bit   ok;
    int   t0;
    int   nwrap, at_wrap, after_wrap, other_wrap;

    // {ch, divider, offset, steps, first change, period}
    tbl[0] = '{0,  0, 8'h00, 3,  10,   9};
    tbl[1] = '{1,  3, 8'h00, 2,  10,   9};
    tbl[2] = '{1, 99, 8'h10, 2, 101, 100};
    tbl[3] = '{2,  8, 8'hFE, 3,  10,   9};
    tbl[4] = '{3, 20, 8'h40, 2,  22,  21};
    tbl[5] = '{0,  9, 8'h05, 2,  11,  10};
    tbl[6] = '{2,  7, 8'h00, 2,  10,   9};

    bus3.ch_en    = '0;
    bus3.sync     = '0;
    bus3.cfg_we   = 1'b0;
    bus3.cfg_sel  = 1'b0;
    bus3.cfg_ch   = '0;
    bus3.cfg_data = '0;

    // Outputs must stay zero while reset is held, whatever the inputs do.
    sys_rst_n    = 1'b0;
    bus.ch_en    = '1;
    bus.sync     = '0;
    bus.cfg_we   = 1'b1;
    bus.cfg_sel  = 1'b1;
    bus.cfg_ch   = '0;
    bus.cfg_data = 16'h0055;
    tick_n(3);
    chk("rst_addr", int'(bus.addr_out), 0);
    chk("rst_wrap", int'(bus.wrap_pulse), 0);
    chk("rst_addr3", int'(bus3.addr_out), 0);

    for (int v = 0; v < 7; v++) begin
      do_reset();
      wr(1'b0, tbl[v].ch, tbl[v].dv);
      wr(1'b1, tbl[v].ch, tbl[v].off);
      tick();
      chk("tbl_offset", addr_of(tbl[v].ch), tbl[v].off);
      t0 = cyc;
      bus.ch_en = '1;
      for (int k = 1; k <= tbl[v].n; k++)
        sb.push_back('{t0 + tbl[v].first + (k - 1) * tbl[v].period, (tbl[v].off + k) % 256});
      while (sb.size() > 0) begin
        e = sb.pop_front();
        wait_change(tbl[v].ch, 2 * tbl[v].period + 4, ok);
        chk("tbl_change_seen", int'(ok), 1);
        if (ok) begin
          chk("tbl_step_cycle", cyc - t0, e.cyc - t0);
          chk("tbl_step_value", addr_of(tbl[v].ch), e.val);
        end
      end
      bus.ch_en = '0;
    end

    // Phase wrap on ch2: pulse is one cycle wide and precedes addr 0x00.
    do_reset();
    bus.ch_en = 4'b0100;
    wait_value(2, 255, 255 * 9 + 20, ok);
    chk("wrap_reach_ff", int'(ok), 1);
    nwrap = 0; at_wrap = -1; after_wrap = -1; other_wrap = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.wrap_pulse[0] || bus.wrap_pulse[1] || bus.wrap_pulse[3]) other_wrap++;
      if (bus.wrap_pulse[2]) begin
        nwrap++;
        at_wrap = addr_of(2);
      end else if (at_wrap >= 0 && after_wrap < 0) begin
        after_wrap = addr_of(2);
      end
    end
    chk("wrap_pulse_cycles", nwrap, 1);
    chk("wrap_addr_during", at_wrap, 255);
    chk("wrap_addr_after", after_wrap, 0);
    chk("wrap_other_ch", other_wrap, 0);

    // Offset update on ch3 with phase parked at 0x10.
    do_reset();
    bus.ch_en = 4'b1000;
    wait_value(3, 16, 200, ok);
    chk("off_reach_10", int'(ok), 1);
    bus.ch_en = '0;
    wr(1'b1, 3, 8'h40);
    chk("off_latency", addr_of(3), 8'h10);
    tick();
    chk("off_applied", addr_of(3), 8'h50);
    wr(1'b1, 3, 8'h00);
    tick();
    chk("off_phase_kept", addr_of(3), 8'h10);

    // Sync on ch0 exactly when accum equals div_eff, then a 5-cycle disable.
    do_reset();
    t0 = cyc;
    bus.ch_en = 4'b0001;
    tick_n(17);
    bus.sync = 4'b0001;
    tick();
    bus.sync = '0;
    chk("sync_no_wrap", int'(bus.wrap_pulse), 0);
    chk("sync_addr_before", addr_of(0), 1);
    tick();
    chk("sync_addr_zero", addr_of(0), 0);
    tick_n(8);
    chk("sync_restart_hold", addr_of(0), 0);
    tick();
    chk("sync_restart_step", addr_of(0), 1);
    bus.ch_en = '0;
    tick_n(5);
    chk("dis_phase_held", addr_of(0), 1);
    bus.ch_en = 4'b0001;
    tick_n(9);
    chk("dis_acc_restart_hold", addr_of(0), 1);
    tick();
    chk("dis_acc_restart_step", addr_of(0), 2);
    chk("sync_timeline", cyc - t0, 43);

    // Divider rewrite on ch1 below the running accum, ch0 alongside.
    do_reset();
    wr(1'b0, 1, 99);
    t0 = cyc;
    bus.ch_en = 4'b0011;
    tick_n(50);
    wr(1'b0, 1, 20);
    chk("rediv_prewrite_used", addr_of(1), 0);
    tick();
    chk("rediv_step_edge", addr_of(1), 0);
    tick();
    chk("rediv_stepped", addr_of(1), 1);
    tick_n(20);
    chk("rediv_new_hold", addr_of(1), 1);
    tick();
    chk("rediv_new_period", addr_of(1), 2);
    chk("rediv_ch0_indep", addr_of(0), 8);

    // Asynchronous reset asserted mid-cycle clears outputs at once.
    #3;
    sys_rst_n = 1'b0;
    #1;
    chk("async_rst_addr", int'(bus.addr_out), 0);
    chk("async_rst_wrap", int'(bus.wrap_pulse), 0);
    clear_inputs();
    tick();
    sys_rst_n = 1'b1;

    // Three-channel build: cfg_ch = 3 is out of range and must be ignored.
    bus3.cfg_we   = 1'b1;
    bus3.cfg_sel  = 1'b1;
    bus3.cfg_ch   = 2'd3;
    bus3.cfg_data = 16'h0040;
    tick();
    bus3.cfg_sel  = 1'b0;
    bus3.cfg_data = 16'h0003;
    tick();
    bus3.cfg_we   = 1'b0;
    tick_n(2);
    chk("ch3_oob_ignored", int'(bus3.addr_out), 0);
    bus3.cfg_we   = 1'b1;
    bus3.cfg_sel  = 1'b1;
    bus3.cfg_ch   = 2'd2;
    bus3.cfg_data = 16'h0022;
    tick();
    bus3.cfg_we   = 1'b0;
    tick();
    chk("ch3_inrange_write", int'(bus3.addr_out), 32'h0022_0000 >> 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/nco_bank.md
NCO_BANK -- requirements
Module: nco_bank

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent NCO channels.
REQ-002 Parameter ADDR_BITS, default 8, width of each channel's table address.
REQ-003 Parameter DIV_BITS, default 16, width of divider and prescale accumulator.
REQ-004 Parameter MIN_DIVIDER, default 8, floor applied to every effective divider.
REQ-005 Derived CH_BITS = max(1, clog2(NUM_CH)).
REQ-006 sys_clk  in  1  single clock; all state changes on its rising edge.
REQ-007 sys_rst_n  in  1  reset, asynchronous and active-low.
REQ-008 ch_en  in  NUM_CH  per-channel run enable, bit i = channel i.
REQ-009 sync  in  NUM_CH  per-channel phase restart, synchronous, level-sampled each cycle.
REQ-010 cfg_we  in  1  configuration write strobe, one write per asserted cycle.
REQ-011 cfg_sel  in  1  write target: 0 = divider register, 1 = phase offset register.
REQ-012 cfg_ch  in  CH_BITS  channel index of the write.
REQ-013 cfg_data  in  DIV_BITS  write data; offset writes use bits [ADDR_BITS-1:0].
REQ-014 addr_out  out  NUM_CH*ADDR_BITS  registered addresses, channel i in bits [i*ADDR_BITS +: ADDR_BITS].
REQ-015 wrap_pulse  out  NUM_CH  one-cycle pulse per channel on phase wrap.

Function
REQ-016 Per channel state: div_reg[DIV_BITS], off_reg[ADDR_BITS], accum[DIV_BITS], phase[ADDR_BITS].
REQ-017 Effective divider div_eff = div_reg if div_reg >= MIN_DIVIDER, else MIN_DIVIDER.
REQ-018 Per channel, priority each cycle: sync > disabled > enabled step.
REQ-019 sync[i]=1: accum<=0, phase<=0, wrap_pulse[i]<=0, regardless of ch_en[i].
REQ-020 ch_en[i]=0 and sync[i]=0: accum<=0, phase holds, wrap_pulse[i]<=0.
REQ-021 Enabled, accum < div_eff: accum<=accum+1, phase holds.
REQ-022 Enabled, accum >= div_eff: accum<=0, phase<=phase+1 modulo 2^ADDR_BITS; step period = div_eff+1 cycles.
REQ-023 wrap_pulse[i]<=1 for exactly the cycle after a step taking phase from all-ones to 0; else 0.
REQ-024 addr_out channel i <= (phase + off_reg) modulo 2^ADDR_BITS, registered from current-cycle register values: one cycle latency after any phase or offset update.
REQ-025 cfg_we=1, cfg_ch < NUM_CH: selected register of channel cfg_ch loads on that edge; accum and phase untouched.
REQ-026 cfg_we=1, cfg_ch >= NUM_CH: write ignored, no state change.
REQ-027 Step decision in a write cycle uses the pre-write div_reg; new value applies from the next cycle.
REQ-028 If a newly written divider is <= current accum, step occurs on the next enabled cycle (>= compare, no lockup).
REQ-029 Channels fully independent; simultaneous events on different channels all take effect in the same cycle.
REQ-030 accum never exceeds div_eff when div_reg is static; no overflow path in DIV_BITS.

Reset
REQ-031 sys_rst_n=0 asynchronously forces: div_reg=0 (div_eff=MIN_DIVIDER), off_reg=0, accum=0, phase=0, addr_out=0, wrap_pulse=0.
REQ-032 Reset assertion mid-step or mid-write discards that update; first step after release is counted from accum=0.
REQ-033 Outputs remain 0 while sys_rst_n=0 regardless of other inputs.

Verification
REQ-034 Reset release, ch_en=1, no writes -> channel 0 addr_out increments every 9 cycles (MIN_DIVIDER+1); first change 10 cycles after first enabled edge (9 + 1 latency).
REQ-035 Write div=3 (below floor) then div=99 to ch1 -> period 9 then 100 cycles; other channels' periods unchanged.
REQ-036 div=8, run ch2 to phase 0xFF, continue -> addr_out 0xFF->0x00 and wrap_pulse[2]=1 for exactly one cycle.
REQ-037 ch3 offset=0x40 while phase=0x10 -> addr_out 0x50 one cycle later; phase itself unaffected.
REQ-038 sync[0]=1 with ch_en[0]=1 during accum=div_eff -> phase=0, no step, no wrap_pulse; ch_en low for 5 cycles -> phase held, accum restarts at 0.
REQ-039 cfg_we with cfg_ch=NUM_CH (NUM_CH=4 is 2 bits, use NUM_CH=3 build, cfg_ch=3) -> no register change in any channel.
